wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter_pkg.sv | 17 +
 rtl/wb_rr_arbiter_if.sv | 44 ++++
 rtl/wb_rr_arbiter_rr_pick.sv | 35 +++
 rtl/wb_rr_arbiter.sv | 115 +++++++++++
 tb/tb_wb_rr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encoding and sizing helpers.
package wb_arb_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_DRAIN  = 2'd2
    } arb_state_t;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between the Wishbone masters, the arbiter and the shared slave.
// The arbiter uses the slave view (it serves the masters); the bench/agents use the master view.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS    = 4,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8
);
    logic [NUM_MASTERS-1:0]                  m_cyc_i;
    logic [NUM_MASTERS-1:0]                  m_stb_i;
    logic [NUM_MASTERS-1:0]                  m_we_i;
    logic [NUM_MASTERS*BUS_DATA_WIDTH/8-1:0] m_sel_i;
    logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]   m_adr_i;
    logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]   m_dat_i;
    logic [BUS_DATA_WIDTH-1:0]               m_dat_o;
    logic [NUM_MASTERS-1:0]                  m_ack_o;
    logic [NUM_MASTERS-1:0]                  m_err_o;
    logic                                    s_cyc_o;
    logic                                    s_stb_o;
    logic                                    s_we_o;
    logic [BUS_DATA_WIDTH/8-1:0]             s_sel_o;
    logic [BUS_ADDR_WIDTH-1:0]               s_adr_o;
    logic [BUS_DATA_WIDTH-1:0]               s_dat_o;
    logic [BUS_DATA_WIDTH-1:0]               s_dat_i;
    logic                                    s_ack_i;
    logic                                    s_err_i;
    logic [NUM_MASTERS-1:0]                  grant_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output grant_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  grant_o
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_idx, wrapping to 0.
module rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IDXW        = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDXW-1:0]        last_idx,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [IDXW-1:0]        gnt_idx
);

    logic found;

    // Two ascending passes: indices above last_idx first, then the wrapped-around ones.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k] && (k > int'(last_idx))) begin
                gnt[k]  = 1'b1;
                gnt_idx = IDXW'(k);
                found   = 1'b1;
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k] && (k <= int'(last_idx))) begin
                gnt[k]  = 1'b1;
                gnt_idx = IDXW'(k);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter letting several Wishbone masters share one slave bus, one access at a time.
// state   | meaning
// IDLE    | no owner; next requester after last_grant is latched and granted
// STROBE  | slave cycle driven for the owner; timeout counter running
// DRAIN   | ack/err already delivered; wait for slave ack/err to fall (or timeout)
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_n_i,
    wb_rr_arbiter_if.slave bus
);

    localparam int SW   = BUS_DATA_WIDTH / 8;
    localparam int AW   = BUS_ADDR_WIDTH;
    localparam int DW   = BUS_DATA_WIDTH;
    localparam int IDXW = idx_width((NUM_MASTERS > MAX_MASTERS) ? MAX_MASTERS : NUM_MASTERS);
    localparam int CNTW = idx_width(TIMEOUT_CYCLES + 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_MASTERS - 1);

    arb_state_t             state;
    logic [IDXW-1:0]        last_grant;
    logic [IDXW-1:0]        owner;
    logic [CNTW-1:0]        cnt;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IDXW-1:0]        pick_idx;
    logic                   cnt_done;

    assign req      = bus.m_cyc_i & bus.m_stb_i;
    assign cnt_done = (cnt == CNTW'(TIMEOUT_CYCLES - 1));

    rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDXW       (IDXW)
    ) u_pick (
        .req     (req),
        .last_idx(last_grant),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= ST_IDLE;
            last_grant  <= LAST_RST;
            owner       <= '0;
            cnt         <= '0;
            bus.grant_o <= '0;
            bus.m_ack_o <= '0;
            bus.m_err_o <= '0;
            bus.m_dat_o <= '0;
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
            bus.s_we_o  <= 1'b0;
            bus.s_sel_o <= '0;
            bus.s_adr_o <= '0;
            bus.s_dat_o <= '0;
        end else begin
            bus.m_ack_o <= '0;
            bus.m_err_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state       <= ST_STROBE;
                        owner       <= pick_idx;
                        cnt         <= '0;
                        bus.grant_o <= pick_gnt;
                        bus.s_cyc_o <= 1'b1;
                        bus.s_stb_o <= 1'b1;
                        bus.s_we_o  <= bus.m_we_i[pick_idx];
                        bus.s_sel_o <= bus.m_sel_i[pick_idx*SW +: SW];
                        bus.s_adr_o <= bus.m_adr_i[pick_idx*AW +: AW];
                        bus.s_dat_o <= bus.m_dat_i[pick_idx*DW +: DW];
                    end
                end
                ST_STROBE: begin
                    if (bus.s_err_i || bus.s_ack_i || cnt_done) begin
                        state       <= ST_DRAIN;
                        cnt         <= '0;
                        bus.s_cyc_o <= 1'b0;
                        bus.s_stb_o <= 1'b0;
                        // err beats ack; no response at all means timeout, also an error
                        if (bus.s_err_i || !bus.s_ack_i) begin
                            bus.m_err_o <= bus.grant_o;
                        end else begin
                            bus.m_ack_o <= bus.grant_o;
                            if (!bus.s_we_o) begin
                                bus.m_dat_o <= bus.s_dat_i;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if ((!bus.s_ack_i && !bus.s_err_i) || cnt_done) begin
                        state       <= ST_IDLE;
                        last_grant  <= owner;
                        bus.grant_o <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: vector table of single transactions plus hand-written
// sequences for round-robin order, timeout, slow ack release and reset during a slave cycle.
module tb_wb_rr_arbiter;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.NUM_MASTERS(NM), .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS   (NM),
        .BUS_DATA_WIDTH(DW),
        .BUS_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:255];
    int slv_lat, slv_extra, slv_mode, hold_cnt, wait_cnt;   // mode: 0 ack, 1 err, 2 ack+err, 3 mute
    int ack_cnt [NM];
    int err_cnt [NM];
    int grant_log [$];
    logic [NM-1:0] prev_grant;

    typedef struct {
        int          mst;
        bit          we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;
        int          mode;
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NM-1:0] v);
        for (int k = 0; k < NM; k++) if (v[k]) return k;
        return -1;
    endfunction

    // One clock: sample just after the edge, update master/slave models, drive next inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if ((bus.m_ack_o | bus.m_err_o) != '0)
            chk("only_owner_pulsed", 64'((bus.m_ack_o | bus.m_err_o) & ~bus.grant_o), 64'(0));
        for (int k = 0; k < NM; k++) begin
            if (bus.m_ack_o[k] || bus.m_err_o[k]) begin
                if (bus.m_ack_o[k]) ack_cnt[k]++;
                if (bus.m_err_o[k]) err_cnt[k]++;
                bus.m_cyc_i[k] = 1'b0;
                bus.m_stb_i[k] = 1'b0;
            end
        end
        if (prev_grant == '0 && bus.grant_o != '0) grant_log.push_back(onehot_idx(bus.grant_o));
        prev_grant = bus.grant_o;
        if (hold_cnt > 0) begin
            hold_cnt--;
        end else begin
            bus.s_ack_i = 1'b0;
            bus.s_err_i = 1'b0;
            if (bus.s_cyc_o && bus.s_stb_o && slv_mode != 3) begin
                if (wait_cnt < slv_lat) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    hold_cnt = slv_extra;
                    if (slv_mode == 0) begin
                        bus.s_ack_i = 1'b1;
                        if (bus.s_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.s_sel_o[b]) mem[bus.s_adr_o][b*8 +: 8] = bus.s_dat_o[b*8 +: 8];
                        end else begin
                            bus.s_dat_i = mem[bus.s_adr_o];
                        end
                    end else begin
                        bus.s_err_i = 1'b1;
                        bus.s_ack_i = (slv_mode == 2);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    task automatic set_req(input int k, input bit we, input logic [7:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        bus.m_we_i[k]            = we;
        bus.m_adr_i[k*AW +: AW]  = adr;
        bus.m_dat_i[k*DW +: DW]  = dat;
        bus.m_sel_i[k*4 +: 4]    = sel;
        bus.m_cyc_i[k]           = 1'b1;
        bus.m_stb_i[k]           = 1'b1;
    endtask

    task automatic run_txn(input int k, input bit we, input logic [7:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [NM-1:0] ack_v,
                           output logic [NM-1:0] err_v, output logic [31:0] rdat, output bit done);
        set_req(k, we, adr, dat, sel);
        done  = 1'b0;
        ack_v = '0;
        err_v = '0;
        rdat  = '0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if ((bus.m_ack_o | bus.m_err_o) != '0) begin
                done  = 1'b1;
                ack_v = bus.m_ack_o;
                err_v = bus.m_err_o;
                rdat  = bus.m_dat_o;
            end
        end
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_grant"}, 64'(bus.grant_o), 64'(0));
        chk({p, "_s_cyc"}, 64'(bus.s_cyc_o), 64'(0));
        chk({p, "_s_stb"}, 64'(bus.s_stb_o), 64'(0));
        chk({p, "_s_we"},  64'(bus.s_we_o),  64'(0));
        chk({p, "_s_sel"}, 64'(bus.s_sel_o), 64'(0));
        chk({p, "_s_adr"}, 64'(bus.s_adr_o), 64'(0));
        chk({p, "_s_dat"}, 64'(bus.s_dat_o), 64'(0));
        chk({p, "_m_ack"}, 64'(bus.m_ack_o), 64'(0));
        chk({p, "_m_err"}, 64'(bus.m_err_o), 64'(0));
        chk({p, "_m_dat"}, 64'(bus.m_dat_o), 64'(0));
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NM; k++) begin
            ack_cnt[k] = 0;
            err_cnt[k] = 0;
        end
        grant_log.delete();
    endtask

    initial begin
        logic [NM-1:0] ack_v, err_v, oh;
        logic [31:0]   rdat;
        bit            done;
        int            n, stb_n, gl;

        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_sel_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 32'h1122_3344;
        slv_lat = 0; slv_extra = 0; slv_mode = 0; hold_cnt = 0; wait_cnt = 0;
        prev_grant = '0;
        clear_counts();

        vecs[0] = '{1, 1'b1, 8'h10, 32'hCAFE_F00D, 4'hF, 2, 0, 1'b0, 1'b1, 32'h0};
        vecs[1] = '{3, 1'b0, 8'h10, 32'h0,         4'hF, 0, 0, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[2] = '{2, 1'b1, 8'h20, 32'hAABB_CCDD, 4'h5, 1, 0, 1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[3] = '{2, 1'b0, 8'h20, 32'h0,         4'hF, 0, 0, 1'b0, 1'b1, 32'h11BB_33DD};
        vecs[4] = '{0, 1'b0, 8'h00, 32'h0,         4'hF, 3, 0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1, 1'b0, 8'h30, 32'h0,         4'hF, 0, 1, 1'b1, 1'b0, 32'h0};
        vecs[6] = '{3, 1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, 1, 2, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{0, 1'b1, 8'h40, 32'h0F0F_0F0F, 4'h8, 0, 0, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{2, 1'b0, 8'h40, 32'h0,         4'hF, 0, 0, 1'b0, 1'b1, 32'h0F00_0000};

        // reset state
        tick();
        tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();

        // single write from master 0: strobe right after the sampling edge, one ack pulse
        set_req(0, 1'b1, 8'h00, 32'hDEAD_BEEF, 4'hF);
        tick();
        chk("lat_s_stb", 64'(bus.s_stb_o), 64'(1));
        chk("lat_s_cyc", 64'(bus.s_cyc_o), 64'(1));
        chk("lat_grant", 64'(bus.grant_o), 64'(4'b0001));
        chk("lat_s_adr", 64'(bus.s_adr_o), 64'(8'h00));
        chk("lat_s_dat", 64'(bus.s_dat_o), 64'(32'hDEAD_BEEF));
        chk("lat_s_sel", 64'(bus.s_sel_o), 64'(4'hF));
        chk("lat_s_we",  64'(bus.s_we_o),  64'(1));
        tick();
        chk("lat_ack", 64'(bus.m_ack_o), 64'(4'b0001));
        tick();
        chk("lat_ack_one_cycle", 64'(bus.m_ack_o), 64'(0));
        chk("lat_slave_mem", 64'(mem[0]), 64'(32'hDEAD_BEEF));
        chk("lat_ack_count", 64'(ack_cnt[0]), 64'(1));
        tick();

        // vector table
        for (int i = 0; i < 9; i++) begin
            slv_lat  = vecs[i].lat;
            slv_mode = vecs[i].mode;
            run_txn(vecs[i].mst, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                    ack_v, err_v, rdat, done);
            oh = NM'(1) << vecs[i].mst;
            chk($sformatf("v%0d_done", i), 64'(done), 64'(1));
            chk($sformatf("v%0d_ack", i), 64'(ack_v), vecs[i].exp_err ? 64'(0) : 64'(oh));
            chk($sformatf("v%0d_err", i), 64'(err_v), vecs[i].exp_err ? 64'(oh) : 64'(0));
            if (vecs[i].chk_dat) chk($sformatf("v%0d_dat", i), 64'(rdat), 64'(vecs[i].exp_dat));
        end
        slv_lat  = 0;
        slv_mode = 0;

        // four simultaneous requesters after reset: served 0,1,2,3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_counts();
        for (int k = 0; k < NM; k++) set_req(k, 1'b1, 8'(8'h50 + k), 32'(k), 4'hF);
        for (int i = 0; i < 100 && (ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3]) < 4; i++) tick();
        repeat (4) tick();
        chk("rr_log_size", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            gl = (grant_log.size() > i) ? grant_log[i] : -1;
            chk($sformatf("rr_order_%0d", i), 64'(gl), 64'(i));
            chk($sformatf("rr_ack_cnt_%0d", i), 64'(ack_cnt[i]), 64'(1));
        end

        // master 2 read with only its ack bit set
        mem[0] = 32'h1234_5678;
        run_txn(2, 1'b0, 8'h00, 32'h0, 4'hF, ack_v, err_v, rdat, done);
        chk("rd2_done", 64'(done), 64'(1));
        chk("rd2_dat", 64'(rdat), 64'(32'h1234_5678));
        chk("rd2_ack", 64'(ack_v), 64'(4'b0100));

        // silent slave: error after TO strobe cycles, then back to idle
        slv_mode = 3;
        set_req(1, 1'b1, 8'h60, 32'h5555_AAAA, 4'hF);
        stb_n = 0;
        done  = 1'b0;
        ack_v = '0;
        err_v = '0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (bus.s_stb_o) stb_n++;
            if ((bus.m_ack_o | bus.m_err_o) != '0) begin
                done  = 1'b1;
                ack_v = bus.m_ack_o;
                err_v = bus.m_err_o;
            end
        end
        chk("to_done", 64'(done), 64'(1));
        chk("to_strobe_cycles", 64'(stb_n), 64'(TO));
        chk("to_err", 64'(err_v), 64'(4'b0010));
        chk("to_no_ack", 64'(ack_v), 64'(0));
        tick();
        chk("to_idle_grant", 64'(bus.grant_o), 64'(0));
        slv_mode = 0;
        tick();

        // slave holds ack 3 extra cycles: stay in drain, single ack, then next master
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_counts();
        slv_extra = 3;
        set_req(0, 1'b0, 8'h10, 32'h0, 4'hF);
        set_req(1, 1'b0, 8'h10, 32'h0, 4'hF);
        done  = 1'b0;
        ack_v = '0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            if (bus.m_ack_o != '0) begin
                done  = 1'b1;
                ack_v = bus.m_ack_o;
            end
        end
        slv_extra = 0;
        chk("hold_first_ack", 64'(ack_v), 64'(4'b0001));
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.grant_o != '0 && n < 20);
        chk("hold_drain_cycles", 64'(n), 64'(4));
        tick();
        chk("hold_next_grant", 64'(bus.grant_o), 64'(4'b0010));
        for (int i = 0; i < 30 && ack_cnt[1] == 0; i++) tick();
        chk("hold_ack_cnt0", 64'(ack_cnt[0]), 64'(1));
        chk("hold_ack_cnt1", 64'(ack_cnt[1]), 64'(1));
        tick();
        tick();

        // reset during strobe: access abandoned, first grant afterwards is master 0
        clear_counts();
        slv_mode = 3;
        set_req(2, 1'b1, 8'h70, 32'h0BAD_0BAD, 4'hF);
        repeat (3) tick();
        chk("rs_pre_grant", 64'(bus.grant_o), 64'(4'b0100));
        chk("rs_pre_stb", 64'(bus.s_stb_o), 64'(1));
        rst_n = 1'b0;
        set_req(0, 1'b1, 8'h71, 32'h600D_600D, 4'hF);
        tick();
        chk_all_zero("rs");
        tick();
        rst_n    = 1'b1;
        slv_mode = 0;
        grant_log.delete();
        for (int i = 0; i < 60 && (ack_cnt[0] + ack_cnt[2]) < 2; i++) tick();
        gl = (grant_log.size() > 0) ? grant_log[0] : -1;
        chk("rs_first_grant", 64'(gl), 64'(0));
        chk("rs_ack_cnt0", 64'(ack_cnt[0]), 64'(1));
        chk("rs_ack_cnt2", 64'(ack_cnt[2]), 64'(1));
        chk("rs_no_err", 64'(err_cnt[0] + err_cnt[2]), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
